// File: rtl/ccip_c1_tx_buffer_pkg.sv
// rtl/ccip_c1_tx_buffer_pkg.sv - CCI-P c1 TX types and burst-buffer definitions
//
// Purpose: the subset of the shell's CCI-P c1 TX types used by the c1 TX
// buffer, the NIC burst constants, the FSM state encodings and a burst-length
// helper. Nothing in this package is a port; it is imported by the buffer and
// by its beat FIFO.
package ccip_c1_tx_buffer_pkg;

  typedef logic [1:0]   t_ccip_vc;
  typedef logic [1:0]   t_ccip_clLen;
  typedef logic [3:0]   t_ccip_c1_req;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  localparam t_ccip_c1_req eREQ_WRLINE_I = 4'h0;

  localparam t_ccip_clLen eCL_LEN_1 = 2'b00;
  localparam t_ccip_clLen eCL_LEN_2 = 2'b01;
  localparam t_ccip_clLen eCL_LEN_4 = 2'b11;

  typedef struct packed {
    logic [5:0]   rsvd1;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd0;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd2;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  // NIC definitions: the largest write burst, which is also the free-entry
  // slack the buffer keeps before signalling almost-full upstream.
  localparam int CCIP_MAX_BURST        = 4;
  localparam int CCIP_C1_ALMFULL_SLACK = CCIP_MAX_BURST;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_ACCEPT,
    IN_DROP
  } t_in_state;

  typedef enum logic {
    OUT_IDLE,
    OUT_BURST
  } t_out_state;

  // Number of lines in a burst whose first header carries cl_len.
  function automatic logic [2:0] burst_len(input t_ccip_clLen cl_len);
    return {1'b0, cl_len} + 3'd1;
  endfunction

endpackage

// File: rtl/ccip_c1_beat_fifo.sv
// rtl/ccip_c1_beat_fifo.sv - single-clock FIFO of c1 write beats {hdr, data}
//
// Purpose: storage for whole admitted bursts. The head is presented
// combinationally on rd_data whenever the FIFO is not empty.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointers only)
//   push, wr_data    store one beat (ignored while full)
//   pop, rd_data     remove the head beat (ignored while empty)
//   count            stored beats, LDEPTH+1 bits so full is representable
//   empty, full      status flags derived from count
module ccip_c1_beat_fifo
  import ccip_c1_tx_buffer_pkg::*;
#(
  parameter int LDEPTH = 4,
  parameter int WIDTH  = $bits(t_ccip_c1_ReqMemHdr) + $bits(t_ccip_clData)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic [LDEPTH:0]   count,
  output logic              empty,
  output logic              full
);

  localparam logic [LDEPTH:0] DEPTH = {1'b1, {LDEPTH{1'b0}}};

  logic [WIDTH-1:0]  mem [2**LDEPTH];
  logic [LDEPTH-1:0] wr_ptr;
  logic [LDEPTH-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_c1_tx_buffer.sv
// rtl/ccip_c1_tx_buffer.sv - burst-atomic elastic buffer on the CCI-P c1 TX path
//
// Purpose: absorbs write bursts (1/2/4 lines) from a transmitter that ignores
// the shell's almost-full, admits or drops each burst whole, and releases a
// burst to the shell only when the shell has room; a started burst always
// completes.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   sTx_c1_in          write beats from the transmitter (packed t_if_ccip_c1_Tx)
//   sRx_c1TxAlmFull    shell c1 almost-full
//   sTx_c1_out         registered write beats to the shell
//   buf_almost_full    free entries below ALMFULL_SLACK
//   occupancy          stored beats
//   drop_cnt           saturating count of dropped beats
//   error              sticky protocol error
module ccip_c1_tx_buffer
  import ccip_c1_tx_buffer_pkg::*;
#(
  parameter int LDEPTH        = 4,
  parameter int ALMFULL_SLACK = CCIP_C1_ALMFULL_SLACK
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [$bits(t_if_ccip_c1_Tx)-1:0]  sTx_c1_in,
  input  logic                               sRx_c1TxAlmFull,
  output logic [$bits(t_if_ccip_c1_Tx)-1:0]  sTx_c1_out,
  output logic                               buf_almost_full,
  output logic [LDEPTH:0]                    occupancy,
  output logic [31:0]                        drop_cnt,
  output logic                               error
);

  localparam int              BEAT_W = $bits(t_ccip_c1_ReqMemHdr) + $bits(t_ccip_clData);
  localparam logic [LDEPTH:0] DEPTH  = {1'b1, {LDEPTH{1'b0}}};
  localparam logic [LDEPTH:0] SLACK  = (LDEPTH+1)'(ALMFULL_SLACK);

  t_if_ccip_c1_Tx     in_beat;
  t_if_ccip_c1_Tx     out_q;
  t_ccip_c1_ReqMemHdr head_hdr;
  t_ccip_clData       head_data;
  logic [BEAT_W-1:0]  fifo_rd_data;
  logic               fifo_empty;
  logic               fifo_full;

  logic [LDEPTH:0]    free_cnt;
  logic [LDEPTH:0]    in_len;
  logic               burst_fits;

  t_in_state          in_state, in_state_nxt;
  logic [1:0]         in_rem, in_rem_nxt;
  logic               push;
  logic               drop;
  logic               in_err;

  t_out_state         out_state, out_state_nxt;
  logic [1:0]         out_rem, out_rem_nxt;
  logic               pop;
  logic               emit;
  logic               out_err;

  assign in_beat    = sTx_c1_in;
  assign sTx_c1_out = out_q;
  assign {head_hdr, head_data} = fifo_rd_data;

  ccip_c1_beat_fifo #(
    .LDEPTH (LDEPTH),
    .WIDTH  (BEAT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({in_beat.hdr, in_beat.data}),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (occupancy),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Admission uses the pre-pop count: a same-cycle pop earns no credit, so a
  // burst admitted at sop always has room for all of its later beats.
  assign free_cnt        = DEPTH - occupancy;
  assign in_len          = (LDEPTH+1)'(burst_len(in_beat.hdr.cl_len));
  assign burst_fits      = (free_cnt >= in_len);
  assign buf_almost_full = (free_cnt < SLACK);

  // Input FSM: admit or drop whole bursts.
  always_comb begin
    in_state_nxt = in_state;
    in_rem_nxt   = in_rem;
    push         = 1'b0;
    drop         = 1'b0;
    in_err       = 1'b0;
    if (in_beat.valid) begin
      if (in_beat.hdr.sop) begin
        // A sop in mid-burst is flagged, then handled as a fresh burst.
        in_err     = (in_state != IN_IDLE);
        in_rem_nxt = in_beat.hdr.cl_len;
        if (burst_fits) begin
          push         = 1'b1;
          in_state_nxt = (in_beat.hdr.cl_len == 2'd0) ? IN_IDLE : IN_ACCEPT;
        end else begin
          drop         = 1'b1;
          in_state_nxt = (in_beat.hdr.cl_len == 2'd0) ? IN_IDLE : IN_DROP;
        end
      end else begin
        case (in_state)
          IN_IDLE: begin
            drop   = 1'b1;
            in_err = 1'b1;
          end
          IN_ACCEPT: begin
            push       = 1'b1;
            in_rem_nxt = in_rem - 2'd1;
            if (in_rem == 2'd1) begin
              in_state_nxt = IN_IDLE;
            end
          end
          IN_DROP: begin
            drop       = 1'b1;
            in_rem_nxt = in_rem - 2'd1;
            if (in_rem == 2'd1) begin
              in_state_nxt = IN_IDLE;
            end
          end
          default: begin
            in_state_nxt = IN_IDLE;
          end
        endcase
      end
    end
  end

  // Output FSM: start a burst only while the shell has room, then finish it
  // regardless of almost-full.
  always_comb begin
    out_state_nxt = out_state;
    out_rem_nxt   = out_rem;
    pop           = 1'b0;
    emit          = 1'b0;
    out_err       = 1'b0;
    if (out_state == OUT_IDLE) begin
      if (!fifo_empty && !sRx_c1TxAlmFull) begin
        pop = 1'b1;
        if (!head_hdr.sop) begin
          out_err = 1'b1;
        end else begin
          emit        = 1'b1;
          out_rem_nxt = head_hdr.cl_len;
          if (head_hdr.cl_len != 2'd0) begin
            out_state_nxt = OUT_BURST;
          end
        end
      end
    end else begin
      if (!fifo_empty) begin
        pop         = 1'b1;
        emit        = 1'b1;
        out_rem_nxt = out_rem - 2'd1;
        if (out_rem == 2'd1) begin
          out_state_nxt = OUT_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state  <= IN_IDLE;
      in_rem    <= '0;
      out_state <= OUT_IDLE;
      out_rem   <= '0;
      out_q     <= '0;
      drop_cnt  <= '0;
      error     <= 1'b0;
    end else begin
      in_state  <= in_state_nxt;
      in_rem    <= in_rem_nxt;
      out_state <= out_state_nxt;
      out_rem   <= out_rem_nxt;
      out_q.valid <= emit;
      // hdr/data hold their last value while no beat is emitted.
      if (emit) begin
        out_q.hdr  <= head_hdr;
        out_q.data <= head_data;
      end
      if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
      if (in_err || out_err) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccip_c1_tx_buffer.sv
// tb/tb_ccip_c1_tx_buffer.sv - directed self-checking bench for ccip_c1_tx_buffer
module tb_ccip_c1_tx_buffer;
  import ccip_c1_tx_buffer_pkg::*;

  localparam int LDEPTH = 4;
  localparam int TX_W   = $bits(t_if_ccip_c1_Tx);

  logic              clk;
  logic              reset;
  logic [TX_W-1:0]   tx_in;
  logic              almfull;
  logic [TX_W-1:0]   tx_out;
  logic              buf_almost_full;
  logic [LDEPTH:0]   occupancy;
  logic [31:0]       drop_cnt;
  logic              error;

  t_if_ccip_c1_Tx    in_s;
  t_if_ccip_c1_Tx    out_s;

  int compared   = 0;
  int mismatched = 0;

  assign tx_in = in_s;
  assign out_s = tx_out;

  ccip_c1_tx_buffer #(
    .LDEPTH        (LDEPTH),
    .ALMFULL_SLACK (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sTx_c1_in       (tx_in),
    .sRx_c1TxAlmFull (almfull),
    .sTx_c1_out      (tx_out),
    .buf_almost_full (buf_almost_full),
    .occupancy       (occupancy),
    .drop_cnt        (drop_cnt),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic t_if_ccip_c1_Tx mk(input logic [41:0] addr, input t_ccip_clLen len,
                                        input logic sop, input logic [31:0] seed);
    t_if_ccip_c1_Tx b;
    b              = '0;
    b.hdr.req_type = eREQ_WRLINE_I;
    b.hdr.address  = addr;
    b.hdr.cl_len   = len;
    b.hdr.sop      = sop;
    b.hdr.mdata    = seed[15:0];
    b.data         = {16{seed}};
    b.valid        = 1'b1;
    return b;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input t_if_ccip_c1_Tx obs, input t_if_ccip_c1_Tx exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed addr %0h len %0d sop %0b v %0b data %0h expected addr %0h len %0d sop %0b v %0b data %0h",
             tag, obs.hdr.address, obs.hdr.cl_len, obs.hdr.sop, obs.valid, obs.data[31:0],
             exp.hdr.address, exp.hdr.cl_len, exp.hdr.sop, exp.valid, exp.data[31:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_s  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  t_if_ccip_c1_Tx a;
  t_if_ccip_c1_Tx b [4];
  t_if_ccip_c1_Tx c0, c1, o;
  t_if_ccip_c1_Tx zero_beat;
  int             seen;

  initial begin
    zero_beat = '0;
    almfull   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b[i] = mk(42'h200 + 42'(i), eCL_LEN_4, (i == 0), 32'h10 + 32'(i));
    end
    c0 = mk(42'h300, eCL_LEN_2, 1'b1, 32'h20);
    c1 = mk(42'h301, eCL_LEN_2, 1'b0, 32'h21);

    // Reset state
    do_reset();
    check_beat("reset_out", out_s, zero_beat);
    check32("reset_occ", 32'(occupancy), 32'd0);
    check32("reset_drop", drop_cnt, 32'd0);
    check32("reset_err", 32'(error), 32'd0);
    check32("reset_almfull", 32'(buf_almost_full), 32'd0);

    // Single 1-CL beat
    a    = mk(42'h100, eCL_LEN_1, 1'b1, 32'hCAFE_0001);
    in_s = a;
    step();
    in_s = '0;
    check32("single_occ_after_push", 32'(occupancy), 32'd1);
    check32("single_no_early_valid", 32'(out_s.valid), 32'd0);
    step();
    check_beat("single_out", out_s, a);
    check32("single_occ_drained", 32'(occupancy), 32'd0);
    step();
    check32("single_valid_low", 32'(out_s.valid), 32'd0);
    check32("single_hdr_hold", 32'(out_s.hdr.address), 32'h100);
    check32("single_drop", drop_cnt, 32'd0);

    // 4-CL burst, almfull rises after first beat; queued 2-CL burst held
    in_s = b[0];
    step();
    in_s = b[1];
    step();
    check_beat("burst_b0", out_s, b[0]);
    check32("burst_pushpop_occ", 32'(occupancy), 32'd1);
    almfull = 1'b1;
    in_s = b[2];
    step();
    check_beat("burst_b1", out_s, b[1]);
    in_s = b[3];
    step();
    check_beat("burst_b2", out_s, b[2]);
    in_s = c0;
    step();
    check_beat("burst_b3", out_s, b[3]);
    in_s = c1;
    step();
    in_s = '0;
    check32("held_valid", 32'(out_s.valid), 32'd0);
    check32("held_occ", 32'(occupancy), 32'd2);
    repeat (3) step();
    check32("held_valid_later", 32'(out_s.valid), 32'd0);
    check32("held_occ_later", 32'(occupancy), 32'd2);
    almfull = 1'b0;
    step();
    check_beat("released_c0", out_s, c0);
    step();
    check_beat("released_c1", out_s, c1);
    step();
    check32("released_idle", 32'(out_s.valid), 32'd0);
    check32("released_occ", 32'(occupancy), 32'd0);
    check32("burst_err", 32'(error), 32'd0);

    // Five 4-CL bursts against a blocked shell: four stored, fifth dropped
    do_reset();
    almfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        in_s = mk(42'h400 + 42'(k * 4 + i), eCL_LEN_4, (i == 0), 32'h40 + 32'(k * 4 + i));
        step();
        if (k == 2 && i == 3) begin
          check32("fill12_almfull", 32'(buf_almost_full), 32'd0);
        end
        if (k == 3 && i == 0) begin
          check32("fill13_occ", 32'(occupancy), 32'd13);
          check32("fill13_almfull", 32'(buf_almost_full), 32'd1);
        end
      end
    end
    in_s = '0;
    check32("fill_occ_full", 32'(occupancy), 32'd16);
    check32("fill_drop", drop_cnt, 32'd4);
    check32("fill_err", 32'(error), 32'd0);
    check32("fill_almfull", 32'(buf_almost_full), 32'd1);
    almfull = 1'b0;
    seen = 0;
    o    = mk(42'h400, eCL_LEN_4, 1'b1, 32'h40);
    for (int n = 0; n < 24; n++) begin
      step();
      if (out_s.valid) begin
        if (seen == 0) begin
          check_beat("drain_first", out_s, o);
        end
        seen++;
      end
    end
    check32("drain_count", 32'(seen), 32'd16);
    check32("drain_occ", 32'(occupancy), 32'd0);

    // 14 single beats, then a 4-CL burst that does not fit, then a single
    do_reset();
    almfull = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_s = mk(42'h500 + 42'(i), eCL_LEN_1, 1'b1, 32'h50 + 32'(i));
      step();
    end
    check32("part_occ14", 32'(occupancy), 32'd14);
    check32("part_almfull", 32'(buf_almost_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_s = mk(42'h580 + 42'(i), eCL_LEN_4, (i == 0), 32'h58 + 32'(i));
      step();
    end
    check32("part_drop", drop_cnt, 32'd4);
    check32("part_occ_after_drop", 32'(occupancy), 32'd14);
    in_s = mk(42'h5F0, eCL_LEN_1, 1'b1, 32'h5F);
    step();
    in_s = '0;
    check32("part_occ15", 32'(occupancy), 32'd15);
    check32("part_drop_kept", drop_cnt, 32'd4);
    check32("part_err", 32'(error), 32'd0);

    // Orphan non-sop beat while idle
    do_reset();
    almfull = 1'b0;
    in_s = mk(42'h600, eCL_LEN_1, 1'b0, 32'h60);
    step();
    in_s = '0;
    check32("orphan_drop", drop_cnt, 32'd1);
    check32("orphan_err", 32'(error), 32'd1);
    check32("orphan_occ", 32'(occupancy), 32'd0);
    step();
    check32("orphan_no_out", 32'(out_s.valid), 32'd0);
    a    = mk(42'h610, eCL_LEN_1, 1'b1, 32'h61);
    in_s = a;
    step();
    in_s = '0;
    step();
    check_beat("orphan_next_ok", out_s, a);
    check32("orphan_err_sticky", 32'(error), 32'd1);

    // Reset pulsed mid-egress
    do_reset();
    in_s = b[0];
    step();
    in_s = b[1];
    step();
    in_s = b[2];
    step();
    check_beat("midrst_b1", out_s, b[1]);
    in_s = b[3];
    #2;
    reset = 1'b1;
    #1;
    check_beat("midrst_out_zero", out_s, zero_beat);
    check32("midrst_occ", 32'(occupancy), 32'd0);
    check32("midrst_drop", drop_cnt, 32'd0);
    in_s = '0;
    step();
    reset = 1'b0;
    in_s = c0;
    step();
    in_s = c1;
    step();
    check_beat("postrst_c0", out_s, c0);
    in_s = '0;
    step();
    check_beat("postrst_c1", out_s, c1);
    step();
    check32("postrst_idle", 32'(out_s.valid), 32'd0);
    check32("postrst_occ", 32'(occupancy), 32'd0);
    check32("postrst_err", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
